// File: rtl/icetap_pkg.sv
// rtl/icetap_pkg.sv - shared state encodings and status layout for the icetap capture path
package icetap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ARMED     = 2'd1,
      ST_TRIGGERED = 2'd2,
      ST_DONE      = 2'd3
   } state_e;

   // Status byte returned by the SPI status read; trig_addr follows as separate bytes.
   typedef struct packed {
      logic [3:0] rsvd;
      logic       done;
      logic       wrapped;
      state_e     state;
   } status_t;

   localparam int STATUS_W = $bits(status_t);

endpackage

// File: rtl/icetap_match.sv
// rtl/icetap_match.sv - sample/previous-sample registers and store/trigger condition decode
module icetap_match #(
   parameter int NR_SIGNALS = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NR_SIGNALS-1:0] signals_i,
   input  logic                  first_i,
   input  logic                  store_always_i,
   input  logic                  trigger_always_i,
   input  logic [NR_SIGNALS-1:0] store_mask_i,
   input  logic [NR_SIGNALS-1:0] trigger_mask_i,
   input  logic [NR_SIGNALS-1:0] trigger_value_i,
   output logic [NR_SIGNALS-1:0] sample_o,
   output logic                  store_cond_o,
   output logic                  trig_cond_o
);

   logic [NR_SIGNALS-1:0] s_q;
   logic [NR_SIGNALS-1:0] p_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s_q <= '0;
         p_q <= '0;
      end else begin
         s_q <= signals_i;
         p_q <= s_q;
      end
   end

   assign sample_o     = s_q;
   assign store_cond_o = store_always_i | first_i | (((s_q ^ p_q) & store_mask_i) != '0);
   assign trig_cond_o  = trigger_always_i |
                         ((s_q & trigger_mask_i) == (trigger_value_i & trigger_mask_i));

endmodule

// File: rtl/icetap_capture_ctrl.sv
// rtl/icetap_capture_ctrl.sv - capture sequencer: circular pre-trigger buffer, post-trigger count, freeze
module icetap_capture_ctrl
   import icetap_pkg::*;
#(
   parameter int NR_SIGNALS = 8,
   parameter int ADDR_BITS  = 8
) (
   input  logic                  scan_clk,
   input  logic                  scan_reset,
   input  logic [NR_SIGNALS-1:0] signals_in,
   input  logic                  cmd_start,
   input  logic                  cmd_abort,
   input  logic                  store_always,
   input  logic                  trigger_always,
   input  logic [NR_SIGNALS-1:0] store_mask,
   input  logic [NR_SIGNALS-1:0] trigger_mask,
   input  logic [NR_SIGNALS-1:0] trigger_value,
   input  logic [ADDR_BITS:0]    post_count,
   output logic                  mem_wr,
   output logic [ADDR_BITS-1:0]  mem_addr,
   output logic [NR_SIGNALS-1:0] mem_wdata,
   output logic [1:0]            state,
   output logic [ADDR_BITS-1:0]  trig_addr,
   output logic                  wrapped,
   output logic                  done
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   // Clamp keeps the post-trigger run from wrapping onto the trigger sample.
   localparam logic [ADDR_BITS:0] MAX_REMAIN = (ADDR_BITS + 1)'(DEPTH - 1);

   state_e                state_q;
   logic [ADDR_BITS-1:0]  wr_ptr_q;
   logic [ADDR_BITS-1:0]  trig_addr_q;
   logic [ADDR_BITS-1:0]  mem_addr_q;
   logic [NR_SIGNALS-1:0] mem_wdata_q;
   logic [ADDR_BITS:0]    remain_q;
   logic                  first_q;
   logic                  wrapped_q;
   logic                  done_q;
   logic                  mem_wr_q;

   logic [NR_SIGNALS-1:0] sample;
   logic                  store_cond;
   logic                  trig_cond;
   logic                  store_d;
   logic [ADDR_BITS:0]    remain_d;

   icetap_match #(
      .NR_SIGNALS (NR_SIGNALS)
   ) u_match (
      .clk_i            (scan_clk),
      .rst_i            (scan_reset),
      .signals_i        (signals_in),
      .first_i          (first_q),
      .store_always_i   (store_always),
      .trigger_always_i (trigger_always),
      .store_mask_i     (store_mask),
      .trigger_mask_i   (trigger_mask),
      .trigger_value_i  (trigger_value),
      .sample_o         (sample),
      .store_cond_o     (store_cond),
      .trig_cond_o      (trig_cond)
   );

   always_comb begin
      store_d  = 1'b0;
      remain_d = (post_count > MAX_REMAIN) ? MAX_REMAIN : post_count;
      if (!cmd_abort) begin
         case (state_q)
            ST_ARMED:     store_d = trig_cond | store_cond;
            ST_TRIGGERED: store_d = store_cond;
            default:      store_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge scan_clk or posedge scan_reset) begin
      if (scan_reset) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         trig_addr_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         remain_q    <= '0;
         first_q     <= 1'b0;
         wrapped_q   <= 1'b0;
         done_q      <= 1'b0;
         mem_wr_q    <= 1'b0;
      end else begin
         mem_wr_q <= store_d;
         if (store_d) begin
            mem_addr_q  <= wr_ptr_q;
            mem_wdata_q <= sample;
            wr_ptr_q    <= wr_ptr_q + ADDR_BITS'(1);
            first_q     <= 1'b0;
            if (wr_ptr_q == '1) begin
               wrapped_q <= 1'b1;
            end
         end

         if (cmd_abort) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE, ST_DONE: begin
                  if (cmd_start) begin
                     state_q   <= ST_ARMED;
                     wr_ptr_q  <= '0;
                     wrapped_q <= 1'b0;
                     first_q   <= 1'b1;
                     done_q    <= 1'b0;
                  end
               end
               ST_ARMED: begin
                  if (trig_cond) begin
                     trig_addr_q <= wr_ptr_q;
                     remain_q    <= remain_d;
                     if (remain_d == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= ST_TRIGGERED;
                     end
                  end
               end
               ST_TRIGGERED: begin
                  if (store_cond) begin
                     remain_q <= remain_q - (ADDR_BITS + 1)'(1);
                     if (remain_q == (ADDR_BITS + 1)'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                     end
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign state     = state_q;
   assign trig_addr = trig_addr_q;
   assign wrapped   = wrapped_q;
   assign done      = done_q;

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// tb/tb_icetap_capture_ctrl.sv - scoreboard bench for icetap_capture_ctrl
module tb_icetap_capture_ctrl;

   logic       scan_clk = 1'b0;
   logic       scan_reset;
   logic [7:0] signals_in;
   logic       cmd_start;
   logic       cmd_abort;
   logic       store_always;
   logic       trigger_always;
   logic [7:0] store_mask;
   logic [7:0] trigger_mask;
   logic [7:0] trigger_value;
   logic [8:0] post_count;
   logic       mem_wr;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [1:0] state;
   logic [7:0] trig_addr;
   logic       wrapped;
   logic       done;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] sb[$];
   logic [15:0] exp_w;

   always #5 scan_clk = ~scan_clk;

   icetap_capture_ctrl #(
      .NR_SIGNALS (8),
      .ADDR_BITS  (8)
   ) dut (
      .scan_clk       (scan_clk),
      .scan_reset     (scan_reset),
      .signals_in     (signals_in),
      .cmd_start      (cmd_start),
      .cmd_abort      (cmd_abort),
      .store_always   (store_always),
      .trigger_always (trigger_always),
      .store_mask     (store_mask),
      .trigger_mask   (trigger_mask),
      .trigger_value  (trigger_value),
      .post_count     (post_count),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .state          (state),
      .trig_addr      (trig_addr),
      .wrapped        (wrapped),
      .done           (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge scan_clk);
      #1;
   endtask

   task automatic push_w(input int addr, input int data);
      sb.push_back({8'(addr), 8'(data)});
   endtask

   // Monitor: every RAM write must match the head of the expected queue.
   always @(negedge scan_clk) begin
      if (mem_wr === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr %0h data %0h want none", mem_addr, mem_wdata);
         end else begin
            exp_w = sb.pop_front();
            check("write_addr_data", {16'h0, mem_addr, mem_wdata}, {16'h0, exp_w});
         end
      end
   end

   initial begin
      scan_reset     = 1'b1;
      signals_in     = 8'h00;
      cmd_start      = 1'b0;
      cmd_abort      = 1'b0;
      store_always   = 1'b0;
      trigger_always = 1'b0;
      store_mask     = 8'h00;
      trigger_mask   = 8'h00;
      trigger_value  = 8'h00;
      post_count     = 9'd0;
      repeat (2) tick();
      @(negedge scan_clk);
      check("reset_state", 32'(state), 32'd0);
      check("reset_mem_wr", 32'(mem_wr), 32'd0);
      check("reset_mem_addr", 32'(mem_addr), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_trig_addr", 32'(trig_addr), 32'd0);
      check("reset_wrapped", 32'(wrapped), 32'd0);
      scan_reset = 1'b0;
      tick();

      // Always-store, always-trigger, zero post count: one write then DONE.
      store_always   = 1'b1;
      trigger_always = 1'b1;
      post_count     = 9'd0;
      signals_in     = 8'hA5;
      cmd_start      = 1'b1;
      push_w(0, 8'hA5);
      tick();
      cmd_start = 1'b0;
      @(negedge scan_clk);
      check("t3_armed", 32'(state), 32'd1);
      tick();
      @(negedge scan_clk);
      check("t3_done_state", 32'(state), 32'd3);
      check("t3_done", 32'(done), 32'd1);
      repeat (5) tick();
      check("t3_sb_empty", 32'(sb.size()), 32'd0);

      // Counting pattern, bit0 store mask, trigger on 0x48, four post samples.
      store_always   = 1'b0;
      trigger_always = 1'b0;
      store_mask     = 8'h01;
      trigger_mask   = 8'h48;
      trigger_value  = 8'h48;
      post_count     = 9'd4;
      for (int k = 0; k < 24; k++) push_w(k, 8'h30 + k);
      for (int j = 0; j < 5; j++) push_w(24 + j, 8'h48 + j);
      for (int k = 0; k < 40; k++) begin
         signals_in = 8'(8'h30 + k);
         cmd_start  = (k == 0);
         tick();
      end
      cmd_start = 1'b0;
      @(negedge scan_clk);
      check("t2_state", 32'(state), 32'd3);
      check("t2_done", 32'(done), 32'd1);
      check("t2_trig_addr", 32'(trig_addr), 32'd24);
      check("t2_wrapped", 32'(wrapped), 32'd0);
      check("t2_sb_empty", 32'(sb.size()), 32'd0);

      // Start and abort together from DONE: abort wins.
      cmd_start = 1'b1;
      cmd_abort = 1'b1;
      tick();
      cmd_start = 1'b0;
      cmd_abort = 1'b0;
      @(negedge scan_clk);
      check("t6_abort_state", 32'(state), 32'd0);
      check("t6_abort_done", 32'(done), 32'd0);
      check("t6_abort_trig_hold", 32'(trig_addr), 32'd24);

      // 300 always-stored samples with no trigger, then abort.
      store_always  = 1'b1;
      trigger_mask  = 8'h80;
      trigger_value = 8'h80;
      for (int k = 0; k < 300; k++) push_w(k & 255, k & 127);
      for (int k = 0; k < 302; k++) begin
         signals_in = 8'(k & 127);
         cmd_start  = (k == 0);
         cmd_abort  = (k == 301);
         tick();
      end
      cmd_start = 1'b0;
      cmd_abort = 1'b0;
      @(negedge scan_clk);
      check("t4_state", 32'(state), 32'd0);
      check("t4_wrapped", 32'(wrapped), 32'd1);
      check("t4_mem_wr", 32'(mem_wr), 32'd0);
      repeat (10) tick();
      check("t4_sb_empty", 32'(sb.size()), 32'd0);

      // Post count beyond depth is clamped to 255 post-trigger writes.
      trigger_mask  = 8'hFF;
      trigger_value = 8'h03;
      post_count    = 9'd300;
      for (int k = 0; k < 259; k++) push_w(k & 255, k & 255);
      for (int k = 0; k < 270; k++) begin
         signals_in = 8'(k);
         cmd_start  = (k == 0);
         tick();
      end
      cmd_start = 1'b0;
      @(negedge scan_clk);
      check("t5_state", 32'(state), 32'd3);
      check("t5_done", 32'(done), 32'd1);
      check("t5_trig_addr", 32'(trig_addr), 32'd3);
      check("t5_wrapped", 32'(wrapped), 32'd1);
      check("t5_sb_empty", 32'(sb.size()), 32'd0);

      // Re-arm from DONE, second start while ARMED must not reset the pointer.
      trigger_mask  = 8'h80;
      trigger_value = 8'h80;
      for (int k = 0; k < 10; k++) push_w(k, k);
      for (int k = 0; k < 12; k++) begin
         signals_in = 8'(k);
         cmd_start  = (k == 0 || k == 5);
         cmd_abort  = (k == 11);
         tick();
      end
      cmd_start = 1'b0;
      cmd_abort = 1'b0;
      @(negedge scan_clk);
      check("t6_rearm_wrapped", 32'(wrapped), 32'd0);
      check("t6_rearm_state", 32'(state), 32'd0);
      repeat (4) tick();
      check("t6_sb_empty", 32'(sb.size()), 32'd0);

      // Reach TRIGGERED with a nonzero trigger address, then reset.
      store_always   = 1'b0;
      store_mask     = 8'h00;
      trigger_mask   = 8'hFF;
      trigger_value  = 8'h05;
      post_count     = 9'd5;
      push_w(0, 8'h00);
      push_w(1, 8'h05);
      for (int k = 0; k < 12; k++) begin
         signals_in = 8'(k);
         cmd_start  = (k == 0);
         tick();
      end
      cmd_start = 1'b0;
      @(negedge scan_clk);
      check("t1_pre_state", 32'(state), 32'd2);
      check("t1_pre_trig_addr", 32'(trig_addr), 32'd1);
      check("t1_sb_empty", 32'(sb.size()), 32'd0);
      tick();
      scan_reset = 1'b1;
      tick();
      @(negedge scan_clk);
      check("t1_state", 32'(state), 32'd0);
      check("t1_mem_wr", 32'(mem_wr), 32'd0);
      check("t1_done", 32'(done), 32'd0);
      check("t1_trig_addr", 32'(trig_addr), 32'd0);
      check("t1_wrapped", 32'(wrapped), 32'd0);
      scan_reset = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
